// File: rtl/wallace_tree_mult_24x24_pkg.sv
// Shared widths and column-height bookkeeping for the 24x24 Wallace-tree multiplier.
// The height helpers are constant functions so generate loops can size each reduction layer.
package wallace_tree_mult_24x24_pkg;

    localparam int MUL_W  = 24;
    localparam int PROD_W = 48;
    localparam int LOW_W  = 8;
    localparam int HI_W   = PROD_W - LOW_W;
    localparam int MAX_H  = MUL_W;

    function automatic int init_height(input int c);
        if (c < 0 || c >= PROD_W - 1) return 0;
        return (c < MUL_W) ? c + 1 : PROD_W - 1 - c;
    endfunction

    // A leftover pair gets a half adder only when the column is still taller than two.
    function automatic int half_adders(input int h);
        return (h > 2 && (h % 3) == 2) ? 1 : 0;
    endfunction

    function automatic int kept_bits(input int h);
        return h - 2 * (h / 3) - half_adders(h);
    endfunction

    function automatic int carries_out(input int h);
        return (h / 3) + half_adders(h);
    endfunction

    function automatic int col_height(input int layer, input int c);
        logic [PROD_W-1:0][7:0] h;
        logic [PROD_W-1:0][7:0] nh;
        int                     cin;
        if (c < 0 || c >= PROD_W) return 0;
        for (int cc = 0; cc < PROD_W; cc++) begin
            h[cc] = 8'(init_height(cc));
        end
        for (int l = 0; l < layer; l++) begin
            for (int cc = 0; cc < PROD_W; cc++) begin
                cin = 0;
                if (cc > 0) cin = carries_out(int'(h[cc-1]));
                nh[cc] = 8'(kept_bits(int'(h[cc])) + cin);
            end
            h = nh;
        end
        return int'(h[c]);
    endfunction

    function automatic int num_layers();
        int tallest;
        for (int l = 0; l < 16; l++) begin
            tallest = 0;
            for (int c = 0; c < PROD_W; c++) begin
                if (col_height(l, c) > tallest) tallest = col_height(l, c);
            end
            if (tallest <= 2) return l;
        end
        return 16;
    endfunction

    localparam int NUM_LAYERS = num_layers();

endpackage

// File: rtl/csa_3to2.sv
// Bit-level 3:2 compressor (full adder); carry carries the weight of the next column up.
module csa_3to2 (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y ^ z;
    assign carry = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/wallace_tree_mult_24x24.sv
// Unsigned 24x24 Wallace-tree multiplier: low 8 product bits resolved, upper 40 left in
// carry-save form (d, f), all outputs registered with asynchronous clear.
module wallace_tree_mult_24x24
    import wallace_tree_mult_24x24_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MUL_W-1:0]        a,
    input  logic [MUL_W-1:0]        b,
    output logic [PROD_W-1:LOW_W]   d,
    output logic [PROD_W-1:LOW_W]   f,
    output logic [LOW_W-1:0]        g
);

    // stage[0] holds the partial-product columns; each later stage is one Wallace layer.
    for (genvar l = 0; l <= NUM_LAYERS; l++) begin : stage
        logic [PROD_W-1:0][MAX_H-1:0] col;
        logic                         unused_pad;
        assign unused_pad = ^col;

        if (l == 0) begin : gen_pp
            for (genvar c = 0; c < PROD_W; c++) begin : gen_col
                localparam int H  = col_height(0, c);
                localparam int LO = (c > MUL_W - 1) ? c - (MUL_W - 1) : 0;
                for (genvar k = 0; k < MAX_H; k++) begin : gen_bit
                    if (k < H) begin : gen_pp_bit
                        assign col[c][k] = a[c - LO - k] & b[LO + k];
                    end else begin : gen_zero
                        assign col[c][k] = 1'b0;
                    end
                end
            end
        end else begin : gen_reduce
            logic [PROD_W-1:0][MAX_H-1:0] sums;
            logic [PROD_W-1:0][MAX_H-1:0] carries;
            logic                         unused_csa;
            assign unused_csa = ^{sums, carries};

            // Next column order: compressor sums, untouched bits, then carries from the column below.
            for (genvar c = 0; c < PROD_W; c++) begin : gen_col
                localparam int H     = col_height(l - 1, c);
                localparam int NFA   = H / 3;
                localparam int NHA   = half_adders(H);
                localparam int NRED  = NFA + NHA;
                localparam int BASE  = 3 * NFA + 2 * NHA;
                localparam int NPASS = H - BASE;
                localparam int NCIN  = carries_out(col_height(l - 1, c - 1));
                for (genvar k = 0; k < MAX_H; k++) begin : gen_bit
                    if (k < NFA) begin : gen_fa
                        csa_3to2 u_csa (
                            .x    (stage[l-1].col[c][3*k]),
                            .y    (stage[l-1].col[c][3*k+1]),
                            .z    (stage[l-1].col[c][3*k+2]),
                            .sum  (sums[c][k]),
                            .carry(carries[c][k])
                        );
                    end else if (k < NRED) begin : gen_ha
                        assign sums[c][k]    = stage[l-1].col[c][BASE-2] ^ stage[l-1].col[c][BASE-1];
                        assign carries[c][k] = stage[l-1].col[c][BASE-2] & stage[l-1].col[c][BASE-1];
                    end else begin : gen_idle
                        assign sums[c][k]    = 1'b0;
                        assign carries[c][k] = 1'b0;
                    end

                    if (k < NRED) begin : gen_sum
                        assign col[c][k] = sums[c][k];
                    end else if (k < NRED + NPASS) begin : gen_pass
                        assign col[c][k] = stage[l-1].col[c][BASE + k - NRED];
                    end else if (k < NRED + NPASS + NCIN) begin : gen_cin
                        assign col[c][k] = carries[c-1][k - NRED - NPASS];
                    end else begin : gen_zero
                        assign col[c][k] = 1'b0;
                    end
                end
            end
        end
    end

    logic [PROD_W-1:0] row0;
    logic [PROD_W-1:0] row1;

    for (genvar c = 0; c < PROD_W; c++) begin : gen_rows
        assign row0[c] = stage[NUM_LAYERS].col[c][0];
        assign row1[c] = stage[NUM_LAYERS].col[c][1];
    end

    logic [LOW_W:0]  low_sum;
    logic [HI_W-1:0] hi0;
    logic [HI_W-1:0] hi1;
    logic [HI_W-1:0] hic;
    logic [HI_W-1:0] hi_sum;
    logic [HI_W-1:0] hi_maj;
    logic            unused_msb;

    // The low-field carry-out is folded in with one 3:2 level so it never ripples upward.
    assign low_sum    = {1'b0, row0[LOW_W-1:0]} + {1'b0, row1[LOW_W-1:0]};
    assign hi0        = row0[PROD_W-1:LOW_W];
    assign hi1        = row1[PROD_W-1:LOW_W];
    assign hic        = {{(HI_W-1){1'b0}}, low_sum[LOW_W]};
    assign hi_sum     = hi0 ^ hi1 ^ hic;
    assign hi_maj     = (hi0 & hi1) | (hic & (hi0 ^ hi1));
    assign unused_msb = hi_maj[HI_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d <= '0;
            f <= '0;
            g <= '0;
        end else begin
            d <= hi_sum;
            f <= {hi_maj[HI_W-2:0], 1'b0};
            g <= low_sum[LOW_W-1:0];
        end
    end

endmodule

// File: tb/tb_wallace_tree_mult_24x24.sv
// Directed and randomized checks of the registered 24x24 carry-save multiplier.
module tb_wallace_tree_mult_24x24;

    logic        clk;
    logic        rst;
    logic [23:0] a;
    logic [23:0] b;
    logic [47:8] d;
    logic [47:8] f;
    logic [7:0]  g;

    int checks;
    int failures;

    wallace_tree_mult_24x24 dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .d  (d),
        .f  (f),
        .g  (g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; results are sampled just after the next rising edge.
    task automatic apply_stimulus(input logic [23:0] x, input logic [23:0] y);
        @(negedge clk);
        a = x;
        b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [39:0] hi;
        rst = 1'b1;
        a   = 24'hFFFFFF;
        b   = 24'hFFFFFF;
        #1;
        checks++;
        if (d !== 40'h0) begin failures++; $display("[TB] FAIL reset_d: got %h expected 0", d); end
        checks++;
        if (f !== 40'h0) begin failures++; $display("[TB] FAIL reset_f: got %h expected 0", f); end
        checks++;
        if (g !== 8'h00) begin failures++; $display("[TB] FAIL reset_g: got %h expected 0", g); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({d, f, g} !== 88'h0) begin
            failures++; $display("[TB] FAIL reset_held: got d=%h f=%h g=%h expected all 0", d, f, g);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        hi = d + f;
        checks++;
        if ({hi, g} !== 48'hFFFFFE000001) begin
            failures++; $display("[TB] FAIL reset_release: got %h expected FFFFFE000001", {hi, g});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({d, f, g} !== 88'h0) begin
            failures++; $display("[TB] FAIL reset_async: got d=%h f=%h g=%h expected all 0", d, f, g);
        end
        @(negedge clk);
        rst = 1'b0;
        a   = 24'h000001;
        b   = 24'h000003;
        @(posedge clk);
        #1;
        hi = d + f;
        checks++;
        if ({hi, g} !== 48'h000000000003) begin
            failures++; $display("[TB] FAIL reset_first_valid: got %h expected 000000000003", {hi, g});
        end
    endtask

    task automatic test_small();
        logic [39:0] hi;
        apply_stimulus(24'h000001, 24'h000003);
        hi = d + f;
        checks++;
        if (g !== 8'h03) begin failures++; $display("[TB] FAIL small_g: got %h expected 03", g); end
        checks++;
        if (hi !== 40'h0) begin failures++; $display("[TB] FAIL small_hi: got %h expected 0", hi); end
    endtask

    task automatic test_max();
        logic [39:0] hi;
        apply_stimulus(24'hFFFFFF, 24'hFFFFFF);
        hi = d + f;
        checks++;
        if (g !== 8'h01) begin failures++; $display("[TB] FAIL max_g: got %h expected 01", g); end
        checks++;
        if (hi !== 40'hFFFFFE0000) begin failures++; $display("[TB] FAIL max_hi: got %h expected FFFFFE0000", hi); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] hi;
        apply_stimulus(24'hFFFFFE, 24'hFFFFFC);
        hi = d + f;
        checks++;
        if (g !== 8'h08) begin failures++; $display("[TB] FAIL compl_g: got %h expected 08", g); end
        checks++;
        if (hi !== 40'hFFFFFA0000) begin failures++; $display("[TB] FAIL compl_hi: got %h expected FFFFFA0000", hi); end
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                apply_stimulus(24'h000001, 24'h000003);
                hi = d + f;
                checks++;
                if ({hi, g} !== 48'h000000000003) begin
                    failures++; $display("[TB] FAIL toggle_small[%0d]: got %h expected 000000000003", i, {hi, g});
                end
            end else begin
                apply_stimulus(24'hFFFFFE, 24'hFFFFFC);
                hi = d + f;
                checks++;
                if ({hi, g} !== 48'hFFFFFA000008) begin
                    failures++; $display("[TB] FAIL toggle_compl[%0d]: got %h expected FFFFFA000008", i, {hi, g});
                end
            end
        end
    endtask

    task automatic test_powers();
        logic [39:0] hi;
        apply_stimulus(24'h800000, 24'h800000);
        hi = d + f;
        checks++;
        if (g !== 8'h00) begin failures++; $display("[TB] FAIL pow_top_g: got %h expected 00", g); end
        checks++;
        if (hi !== 40'h4000000000) begin failures++; $display("[TB] FAIL pow_top_hi: got %h expected 4000000000", hi); end
        apply_stimulus(24'h000080, 24'h000002);
        hi = d + f;
        checks++;
        if (g !== 8'h00) begin failures++; $display("[TB] FAIL pow_low_g: got %h expected 00", g); end
        checks++;
        if (hi !== 40'h0000000001) begin failures++; $display("[TB] FAIL pow_low_hi: got %h expected 01", hi); end
    endtask

    task automatic test_random();
        logic [39:0] hi;
        logic [47:0] expected;
        logic        held;
        int          r;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            rst  = 1'b0;
            a    = 24'($urandom);
            b    = 24'($urandom);
            held = 1'b0;
            r    = int'($urandom_range(0, 99));
            if (r < 3) begin
                #($urandom_range(1, 2));
                rst = 1'b1;
                #1;
                checks++;
                if ({d, f, g} !== 88'h0) begin
                    failures++; $display("[TB] FAIL rand_rst[%0d]: got d=%h f=%h g=%h expected all 0", i, d, f, g);
                end
                if (r == 0) held = 1'b1;
                else begin
                    #1;
                    rst = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            expected = held ? 48'h0 : (48'(a) * 48'(b));
            hi = d + f;
            checks++;
            if ({hi, g} !== expected) begin
                failures++; $display("[TB] FAIL rand_prod[%0d]: a=%h b=%h got %h expected %h", i, a, b, {hi, g}, expected);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        a        = '0;
        b        = '0;
        test_reset();
        test_small();
        test_max();
        test_back_to_back();
        test_powers();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
